// File: rtl/stream_result_sink.sv
// Result stream terminator: accepts a programmed word count into a small FIFO
// and writes it to consecutive result-memory addresses, then pulses done.
module stream_result_sink #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_async,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [CNT_WIDTH-1:0]  num_words,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_ready,
    output logic                  busy,
    output logic                  done
);

    localparam int PW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, RECV, DRAIN, DONE} state_t;

    state_t                state_q, state_d;
    logic [CNT_WIDTH-1:0]  num_q, rx_cnt, wr_cnt;
    logic [CNT_WIDTH-1:0]  rx_nxt, wr_nxt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW:0]           wptr, rptr;
    logic                  full, empty, push, pop, go;

    // Extra pointer MSB distinguishes full from empty at equal indices.
    assign empty = (wptr == rptr);
    assign full  = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);

    assign s_ready = (state_q == RECV) && !full && (rx_cnt < num_q);
    assign wr_en   = ((state_q == RECV) || (state_q == DRAIN)) && !empty;
    assign wr_data = mem[rptr[PW-1:0]];
    assign wr_addr = addr_q;
    assign busy    = (state_q == RECV) || (state_q == DRAIN);
    assign done    = (state_q == DONE);

    assign push   = s_valid && s_ready;
    assign pop    = wr_en && wr_ready;
    assign go     = (state_q == IDLE) && start;
    assign rx_nxt = rx_cnt + {{(CNT_WIDTH-1){1'b0}}, push};
    assign wr_nxt = wr_cnt + {{(CNT_WIDTH-1){1'b0}}, pop};

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start)
                    state_d = (num_words != '0) ? RECV : DONE;
            end
            RECV: begin
                if (wr_nxt == num_q)
                    state_d = DONE;
                else if (rx_nxt == num_q)
                    state_d = DRAIN;
            end
            DRAIN: begin
                if (wr_nxt == num_q)
                    state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            num_q  <= '0;
            rx_cnt <= '0;
            wr_cnt <= '0;
            addr_q <= '0;
            wptr   <= '0;
            rptr   <= '0;
        end else if (go) begin
            num_q  <= num_words;
            rx_cnt <= '0;
            wr_cnt <= '0;
            addr_q <= base_addr;
            wptr   <= '0;
            rptr   <= '0;
        end else begin
            if (push) begin
                wptr   <= wptr + 1'b1;
                rx_cnt <= rx_nxt;
            end
            if (pop) begin
                rptr   <= rptr + 1'b1;
                addr_q <= addr_q + 1'b1;
                wr_cnt <= wr_nxt;
            end
        end
    end

    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (push) begin
            mem[wptr[PW-1:0]] <= s_data;
        end
    end

endmodule

// File: tb/tb_stream_result_sink.sv
// Scoreboard bench for stream_result_sink: expected writes are queued per run
// and matched against every accepted memory write.
`timescale 1ns/1ps
module tb_stream_result_sink;

    localparam int DW    = 16;
    localparam int DEPTH = 8;
    localparam int AW    = 16;
    localparam int CW    = 16;

    logic          clk = 1'b0;
    logic          rst_async;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [CW-1:0] num_words;
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_ready;
    logic          busy;
    logic          done;

    stream_result_sink #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst_async(rst_async), .start(start),
        .base_addr(base_addr), .num_words(num_words),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ready(wr_ready), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t           sb_q[$];
    logic [DW-1:0] stim_q[$];

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int tx_idx, n_wr, done_cnt, max_occ;
    int start_cyc, first_acc_cyc, first_wr_cyc, last_wr_cyc, done_cyc;
    logic          stall_pend = 1'b0;
    logic [AW-1:0] stall_addr;
    logic [DW-1:0] stall_data;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
    endtask

    task automatic drive_data();
        s_data = (tx_idx < stim_q.size()) ? stim_q[tx_idx] : 16'h7777;
    endtask

    // Observe at the falling edge, advance past the rising edge, redrive.
    task automatic tick();
        logic acc, wrf;
        wr_t  e;
        @(negedge clk);
        cyc++;
        acc = s_valid && s_ready;
        wrf = wr_en && wr_ready;
        if (stall_pend) begin
            check("stall_en", 32'(wr_en), 32'd1);
            check("stall_addr", 32'(wr_addr), 32'(stall_addr));
            check("stall_data", 32'(wr_data), 32'(stall_data));
        end
        stall_pend = wr_en && !wr_ready;
        stall_addr = wr_addr;
        stall_data = wr_data;
        if (acc && first_acc_cyc < 0)
            first_acc_cyc = cyc;
        if (wrf) begin
            if (sb_q.size() == 0) begin
                check("unexpected_wr", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("wr_addr", 32'(wr_addr), 32'(e.addr));
                check("wr_data", 32'(wr_data), 32'(e.data));
            end
            n_wr++;
            if (first_wr_cyc < 0)
                first_wr_cyc = cyc;
            last_wr_cyc = cyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            check("busy_at_done", 32'(busy), 32'd0);
        end
        @(posedge clk);
        #1;
        if (acc)
            tx_idx++;
        if (tx_idx - n_wr > max_occ)
            max_occ = tx_idx - n_wr;
        drive_data();
    endtask

    task automatic start_run(input logic [AW-1:0] base, input int n);
        sb_q.delete();
        tx_idx = 0;
        n_wr = 0;
        done_cnt = 0;
        max_occ = 0;
        first_acc_cyc = -1;
        first_wr_cyc = -1;
        last_wr_cyc = -1;
        done_cyc = -1;
        for (int i = 0; i < n; i++)
            sb_q.push_back('{addr: base + AW'(i), data: stim_q[i]});
        start = 1'b1;
        base_addr = base;
        num_words = CW'(n);
        drive_data();
        tick();
        start_cyc = cyc;
        start = 1'b0;
    endtask

    task automatic finish_run(input string tag, input int n,
                              input bit rnd, input int budget);
        int k = 0;
        while (done_cnt == 0 && k < budget) begin
            if (rnd) begin
                s_valid = 1'($urandom_range(0, 1));
                wr_ready = 1'($urandom_range(0, 1));
            end
            tick();
            k++;
        end
        if (done_cnt == 0)
            check({tag, "_timeout"}, 32'd0, 32'd1);
        s_valid = 1'b1;
        wr_ready = 1'b1;
        for (int i = 0; i < 3; i++)
            tick();
        check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
        check({tag, "_n_wr"}, 32'(n_wr), 32'(n));
        check({tag, "_rx"}, 32'(tx_idx), 32'(n));
        check({tag, "_sb_left"}, 32'(sb_q.size()), 32'd0);
        check({tag, "_occ"}, 32'(max_occ <= DEPTH), 32'd1);
        if (n > 0)
            check({tag, "_done_lat"}, 32'(done_cyc), 32'(last_wr_cyc + 1));
    endtask

    initial begin
        rst_async = 1'b1;
        start = 1'b0;
        base_addr = '0;
        num_words = '0;
        s_valid = 1'b0;
        s_data = '0;
        wr_ready = 1'b0;
        #1;
        check("rst_s_ready", 32'(s_ready), 32'd0);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        tx_idx = 0;
        n_wr = 0;
        done_cnt = 0;
        tick();
        tick();
        rst_async = 1'b0;
        tick();

        // Basic: full-rate stream, signed extremes
        stim_q = '{16'h0005, 16'hFFFD, 16'h7FFF, 16'h8000};
        s_valid = 1'b1;
        wr_ready = 1'b1;
        start_run(16'h0100, 4);
        finish_run("basic", 4, 1'b0, 30);
        check("basic_first_acc", 32'(first_acc_cyc), 32'(start_cyc + 1));
        check("basic_first_wr", 32'(first_wr_cyc), 32'(start_cyc + 2));
        check("basic_rate", 32'(last_wr_cyc - first_wr_cyc), 32'd3);

        // Backpressure with an ignored start during the stall
        stim_q.delete();
        for (int i = 0; i < 12; i++)
            stim_q.push_back(DW'(i * 1000 - 5000));
        s_valid = 1'b1;
        wr_ready = 1'b0;
        start_run(16'h0200, 12);
        for (int i = 0; i < 20; i++) begin
            if (i == 10) begin
                start = 1'b1;
                base_addr = 16'h0000;
                num_words = 16'd3;
            end
            tick();
            start = 1'b0;
        end
        check("bp_accepted", 32'(tx_idx), 32'd8);
        check("bp_s_ready", 32'(s_ready), 32'd0);
        check("bp_no_wr", 32'(n_wr), 32'd0);
        check("bp_busy", 32'(busy), 32'd1);
        wr_ready = 1'b1;
        finish_run("bp", 12, 1'b0, 60);
        check("bp_max_occ", 32'(max_occ), 32'(DEPTH));

        // Random valid/ready, data = index
        stim_q.delete();
        for (int i = 0; i < 100; i++)
            stim_q.push_back(DW'(i));
        s_valid = 1'b1;
        wr_ready = 1'b0;
        start_run(16'h0400, 100);
        finish_run("rand", 100, 1'b1, 3000);

        // Zero-length job
        stim_q.delete();
        s_valid = 1'b1;
        wr_ready = 1'b1;
        start_run(16'h0800, 0);
        finish_run("zero", 0, 1'b0, 10);
        check("zero_done_lat", 32'(done_cyc), 32'(start_cyc + 1));

        // Address wrap
        stim_q = '{16'hFFFF, 16'hFFFE, 16'h0007, 16'h0008};
        start_run(16'hFFFE, 4);
        finish_run("wrap", 4, 1'b0, 30);

        // Reset in the middle of a 10-word job
        stim_q.delete();
        for (int i = 0; i < 10; i++)
            stim_q.push_back(DW'(16'h0A00 + i));
        start_run(16'h0300, 10);
        for (int k = 0; k < 20 && tx_idx < 3; k++)
            tick();
        #2;
        rst_async = 1'b1;
        #1;
        check("mid_s_ready", 32'(s_ready), 32'd0);
        check("mid_wr_en", 32'(wr_en), 32'd0);
        check("mid_wr_addr", 32'(wr_addr), 32'd0);
        check("mid_wr_data", 32'(wr_data), 32'd0);
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_done", 32'(done), 32'd0);
        stall_pend = 1'b0;
        sb_q.delete();
        done_cnt = 0;
        for (int i = 0; i < 3; i++)
            tick();
        rst_async = 1'b0;
        for (int i = 0; i < 2; i++)
            tick();
        check("mid_no_done", 32'(done_cnt), 32'd0);
        stim_q = '{16'h1234, 16'hCDEF};
        start_run(16'h0500, 2);
        finish_run("after_rst", 2, 1'b0, 30);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
